vm_order_sequencer: RTL and testbench
=====================================

// Module: vm_order_sequencer
// PURPOSE
//  Order-execution controller of the book vending machine, between the switch/button front end and display_mux.
//  - Latches a book code and quantity.
//  - Checks per-book stock and computes the order total.
//  - Sequences dispensing one book at a time over a req/ack handshake with the dispenser.
//  - Drives mode/qty_now/total_sum for the 7-segment display mux.
// PARAMETERS
//  NUM_BOOKS    16    stock table entries; indexed by code_sel
//  INIT_STOCK   9     per-book stock after reset or restock
//  HOLD_CYCLES  50M   cycles DONE/ERROR are held for display (1 s at 50 MHz)
//  ACK_TIMEOUT  1000  max cycles waiting for disp_ack before fault
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  code_sel    in   4   book code (sw9..sw6)
//  qty_sel     in   5   requested quantity (sw5..sw1), 0..31
//  restock     in   1   1-cycle pulse: refill stock[code_sel] to INIT_STOCK
//  btn_order   in   1   1-cycle pulse: start order
//  btn_cancel  in   1   1-cycle pulse: cancel order
//  price       in   10  unit price of code_sel (external price ROM, combinational)
//  disp_ack    in   1   dispenser done with current book
//  disp_req    out  1   request dispenser to drop one book
//  mode        out  3   0 IDLE, 1 CHECK, 2 DISPENSE, 3 WAIT_ACK, 4 DONE, 5 ERROR
//  qty_now     out  7   books still to dispense (zero-extended)
//  total_sum   out  17  qty x price of the accepted order
//  busy        out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset
//  - rst (sync, active-high) forces IDLE from any state, mid-handshake included.
//  - All outputs reset to 0; every stock entry resets to INIT_STOCK.
//  IDLE
//  - btn_order with qty_sel != 0 latches code/qty -> CHECK.
//  - btn_order with qty_sel == 0 is ignored.
//  - btn_cancel in the same cycle as btn_order wins: order ignored.
//  - restock is honoured only in IDLE; ignored elsewhere.
//  CHECK (exactly 1 cycle)
//  - stock[code] < qty: no stock change, -> ERROR.
//  - Otherwise total_sum <= qty*price (15-bit product, zero-extended, no overflow), qty_now <= qty, -> DISPENSE.
//  - btn_cancel in CHECK -> IDLE; total_sum and qty_now clear.
//  DISPENSE (1 cycle, disp_req=0)
//  - -> WAIT_ACK.
//  - btn_cancel -> DONE; items already given stay counted.
//  WAIT_ACK
//  - disp_req=1, held until disp_ack is sampled high.
//  - On ack, next cycle: disp_req=0, stock[code]--, qty_now--.
//    - qty_now reaches 0, or a cancel is pending -> DONE.
//    - Otherwise -> DISPENSE.
//  - btn_cancel in WAIT_ACK is latched; the current item always completes.
//  - ACK_TIMEOUT cycles without ack -> ERROR, disp_req=0, stock unchanged for that item.
//  - disp_ack outside WAIT_ACK is ignored.
//  DONE / ERROR
//  - Held HOLD_CYCLES cycles; btn_order/btn_cancel ignored. Then -> IDLE.
//  - DONE keeps total_sum; qty_now shows 0 (or remainder if cancelled).
//  - Entry to IDLE clears qty_now and total_sum.
//  General
//  - Stock never underflows; one dispensed item per ack.
//  - Fixed latency btn_order -> first disp_req rise: 3 cycles.
// TESTING (bench uses HOLD_CYCLES=4, ACK_TIMEOUT=8)
//  1. rst; code=3, qty=2, price=500, order; ack each req 2 cycles later
//     -> total_sum=1000; two req pulses; stock[3]=7; DONE 4 cycles; IDLE.
//  2. code=5, qty=10 (stock 9), order -> CHECK then ERROR; no disp_req; stock[5]=9.
//  3. qty=3, cancel during 1st WAIT_ACK -> 1st item completes; DONE with qty_now=2; stock -1 only.
//  4. qty=1, never ack -> req high 8 cycles, ERROR, req low; stock unchanged.
//  5. order+cancel same cycle in IDLE -> stays IDLE.
//  6. qty=0 order -> ignored.
//  7. restock in IDLE after test 1 -> stock[3]=9.
//  8. rst mid-WAIT_ACK -> next cycle IDLE; all outputs 0.

Source files
------------

// File: rtl/vm_order_sequencer.sv
// Order-execution controller for the book vending machine.
// Latches a book code and quantity, checks per-book stock, computes the
// order total and dispenses one book at a time over a req/ack handshake.
// mode/qty_now/total_sum feed the 7-segment display mux.
module vm_order_sequencer #(
  parameter int NUM_BOOKS   = 16,
  parameter int INIT_STOCK  = 9,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  code_sel,
  input  logic [4:0]  qty_sel,
  input  logic        restock,
  input  logic        btn_order,
  input  logic        btn_cancel,
  input  logic [9:0]  price,
  input  logic        disp_ack,
  output logic        disp_req,
  output logic [2:0]  mode,
  output logic [6:0]  qty_now,
  output logic [16:0] total_sum,
  output logic        busy
);

  localparam int STOCK_W = $clog2(INIT_STOCK + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_DISPENSE = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DONE     = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  state_t              state_reg;
  logic [3:0]          code_reg;
  logic [4:0]          qty_reg;
  logic [4:0]          rem_reg;
  logic [16:0]         total_reg;
  logic                req_reg;
  logic                cancel_pend_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [TO_W-1:0]     ack_cnt_reg;

  logic [STOCK_W-1:0]  stock_mem [NUM_BOOKS];
  logic [STOCK_W-1:0]  stock_cur;
  logic [14:0]         order_product;
  logic                restock_en;
  logic                dec_en;

  assign stock_cur     = stock_mem[code_reg];
  assign order_product = 15'(qty_reg) * 15'(price);
  // Refill only while idle; a book leaves the table once per accepted ack.
  assign restock_en    = (state_reg == S_IDLE) && restock;
  assign dec_en        = (state_reg == S_WAIT_ACK) && disp_ack;

  assign disp_req  = req_reg;
  assign mode      = state_reg;
  assign qty_now   = {2'b00, rem_reg};
  assign total_sum = total_reg;
  assign busy      = (state_reg != S_IDLE);

  // Per-book stock counters: reset/restock refill, ack decrements (never below zero).
  generate
    for (genvar gi = 0; gi < NUM_BOOKS; gi++) begin : g_stock
      always_ff @(posedge clk) begin
        if (rst) begin
          stock_mem[gi] <= STOCK_W'(INIT_STOCK);
        end else if (restock_en && (code_sel == 4'(gi))) begin
          stock_mem[gi] <= STOCK_W'(INIT_STOCK);
        end else if (dec_en && (code_reg == 4'(gi)) && (stock_mem[gi] != '0)) begin
          stock_mem[gi] <= stock_mem[gi] - STOCK_W'(1);
        end
      end
    end
  endgenerate

  // Order FSM with registered handshake and display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      code_reg        <= '0;
      qty_reg         <= '0;
      rem_reg         <= '0;
      total_reg       <= '0;
      req_reg         <= 1'b0;
      cancel_pend_reg <= 1'b0;
      hold_cnt_reg    <= '0;
      ack_cnt_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          cancel_pend_reg <= 1'b0;
          // A simultaneous cancel suppresses the order; zero quantity is not an order.
          if (btn_order && !btn_cancel && (qty_sel != 5'd0)) begin
            code_reg  <= code_sel;
            qty_reg   <= qty_sel;
            state_reg <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (btn_cancel) begin
            total_reg <= '0;
            rem_reg   <= '0;
            state_reg <= S_IDLE;
          end else if (32'(stock_cur) < 32'(qty_reg)) begin
            hold_cnt_reg <= '0;
            state_reg    <= S_ERROR;
          end else begin
            total_reg <= 17'(order_product);
            rem_reg   <= qty_reg;
            state_reg <= S_DISPENSE;
          end
        end
        S_DISPENSE: begin
          if (btn_cancel) begin
            hold_cnt_reg <= '0;
            state_reg    <= S_DONE;
          end else begin
            req_reg     <= 1'b1;
            ack_cnt_reg <= '0;
            state_reg   <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          // A cancel here only stops further items; the book in flight completes.
          if (btn_cancel) cancel_pend_reg <= 1'b1;
          if (disp_ack) begin
            req_reg <= 1'b0;
            rem_reg <= rem_reg - 5'd1;
            if ((rem_reg == 5'd1) || cancel_pend_reg || btn_cancel) begin
              hold_cnt_reg <= '0;
              state_reg    <= S_DONE;
            end else begin
              state_reg <= S_DISPENSE;
            end
          end else if (ack_cnt_reg == TO_W'(ACK_TIMEOUT - 1)) begin
            req_reg      <= 1'b0;
            hold_cnt_reg <= '0;
            state_reg    <= S_ERROR;
          end else begin
            ack_cnt_reg <= ack_cnt_reg + TO_W'(1);
          end
        end
        S_DONE, S_ERROR: begin
          if (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
            rem_reg         <= '0;
            total_reg       <= '0;
            cancel_pend_reg <= 1'b0;
            state_reg       <= S_IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm_order_sequencer.sv
// Bench for vm_order_sequencer: directed scenarios plus randomized orders
// checked against an order-level model of stock, totals and outcomes.
module tb_vm_order_sequencer;

  localparam int HOLD = 4;
  localparam int TO   = 8;
  localparam int INIT = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  code_sel = '0;
  logic [4:0]  qty_sel = '0;
  logic        restock = 1'b0;
  logic        btn_order = 1'b0;
  logic        btn_cancel = 1'b0;
  logic [9:0]  price = '0;
  logic        disp_ack = 1'b0;
  logic        disp_req;
  logic [2:0]  mode;
  logic [6:0]  qty_now;
  logic [16:0] total_sum;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int model_stock [16];

  // Observations from one order run
  int o_check_mode, o_check_busy, o_post_mode, o_post_total, o_latency;
  int o_reqs, o_req_cycles, o_req_in_disp, o_fin_mode, o_fin_qty, o_fin_total;
  int o_fin_req, o_hold, o_idle_all, o_timeout;
  // Model predictions for one order
  int e_post, e_total, e_reqs, e_fin_mode, e_fin_qty, e_used;

  always #5 clk = ~clk;

  vm_order_sequencer #(
    .NUM_BOOKS(16), .INIT_STOCK(INIT), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .code_sel(code_sel), .qty_sel(qty_sel),
    .restock(restock), .btn_order(btn_order), .btn_cancel(btn_cancel),
    .price(price), .disp_ack(disp_ack), .disp_req(disp_req), .mode(mode),
    .qty_now(qty_now), .total_sum(total_sum), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outcome of an order from stock level and operator/dispenser behaviour.
  // cancel_mode: 0 none, -1 cancel before the first book, k>0 cancel while book k is requested.
  task automatic predict(input int code, input int qty, input int prc,
                         input int cancel_mode, input bit never_ack);
    if (qty > model_stock[code]) begin
      e_post = 5; e_total = 0; e_reqs = 0; e_fin_mode = 5; e_fin_qty = 0; e_used = 0;
    end else begin
      e_post = 2; e_total = qty * prc;
      if (never_ack) begin
        e_reqs = 1; e_fin_mode = 5; e_fin_qty = qty; e_used = 0;
      end else if (cancel_mode < 0) begin
        e_reqs = 0; e_fin_mode = 4; e_fin_qty = qty; e_used = 0;
      end else if (cancel_mode > 0 && cancel_mode <= qty) begin
        e_reqs = cancel_mode; e_fin_mode = 4; e_fin_qty = qty - cancel_mode; e_used = cancel_mode;
      end else begin
        e_reqs = qty; e_fin_mode = 4; e_fin_qty = 0; e_used = qty;
      end
    end
  endtask

  // Drives one order end to end acting as the dispenser; records observations.
  task automatic run_order(input int code, input int qty, input int prc, input int ack_dly,
                           input int cancel_mode, input bit never_ack, input bit restock_busy);
    int  cyc;
    int  wcnt;
    int  guard;
    bit  prev_req;
    bit  fin;
    code_sel = 4'(code); qty_sel = 5'(qty); price = 10'(prc);
    btn_order = 1'b1;
    step();
    btn_order = 1'b0;
    o_check_mode = int'(mode); o_check_busy = int'(busy);
    step();
    o_post_mode = int'(mode); o_post_total = int'(total_sum);
    o_reqs = 0; o_req_cycles = 0; o_req_in_disp = 0; o_latency = -1; o_timeout = 0;
    cyc = 1; wcnt = 0; guard = 0; prev_req = 1'b0; fin = 1'b0;
    while (!fin) begin
      btn_cancel = 1'b0; disp_ack = 1'b0;
      restock = restock_busy && (mode != 3'd0);
      if (mode == 3'd4 || mode == 3'd5) begin
        fin = 1'b1;
      end else if (guard > 2000) begin
        o_timeout = 1; fin = 1'b1;
      end else begin
        if (mode == 3'd2) begin
          if (disp_req) o_req_in_disp++;
          if (cancel_mode < 0 && o_reqs == 0) btn_cancel = 1'b1;
        end
        if (disp_req) begin
          o_req_cycles++;
          if (!prev_req) begin
            o_reqs++; wcnt = 0;
            if (o_latency < 0) o_latency = cyc + 1;
          end else begin
            wcnt++;
          end
          if (cancel_mode > 0 && cancel_mode == o_reqs && wcnt == 0) btn_cancel = 1'b1;
          if (!never_ack && wcnt == ack_dly) disp_ack = 1'b1;
        end
        prev_req = disp_req;
        step(); cyc++; guard++;
      end
    end
    o_fin_mode = int'(mode); o_fin_qty = int'(qty_now);
    o_fin_total = int'(total_sum); o_fin_req = int'(disp_req);
    o_hold = 0; guard = 0;
    while ((mode == 3'd4 || mode == 3'd5) && guard < 100) begin
      restock = restock_busy;
      o_hold++;
      step(); guard++;
    end
    restock = 1'b0;
    if (guard >= 100) o_timeout = 1;
    o_idle_all = (mode == 3'd0 && qty_now == 7'd0 && total_sum == 17'd0 && busy == 1'b0 &&
                  disp_req == 1'b0) ? 1 : 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_stock[i] = INIT;
    n_checks++;
    if ({mode, disp_req, qty_now, total_sum, busy} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got mode=%0d req=%0b qty=%0d total=%0d busy=%0b want all 0",
               mode, disp_req, qty_now, total_sum, busy);
    end
    $display("reset: mode=%0d busy=%0b", mode, busy);
  endtask

  // Stock level is read back through order outcomes: one book too many must fail,
  // exactly the level must be accepted (then cancelled before any book drops).
  task automatic test_stock_probe(input int code, input int exp_level);
    run_order(code, exp_level + 1, 1, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if (o_post_mode !== 5) begin
      n_fail++;
      $display("FAIL probe_over code=%0d got mode %0d want 5 (stock %0d)", code, o_post_mode, exp_level);
    end
    if (exp_level > 0) begin
      run_order(code, exp_level, 1, 0, -1, 1'b0, 1'b0);
      n_checks++;
      if (o_post_mode !== 2 || o_fin_mode !== 4 || o_fin_qty !== exp_level || o_reqs !== 0) begin
        n_fail++;
        $display("FAIL probe_exact code=%0d got post=%0d fin=%0d qty=%0d reqs=%0d want 2/4/%0d/0",
                 code, o_post_mode, o_fin_mode, o_fin_qty, o_reqs, exp_level);
      end
    end
    $display("probe: code=%0d stock=%0d", code, exp_level);
  endtask

  task automatic test_basic_order();
    run_order(3, 2, 500, 2, 0, 1'b0, 1'b0);
    model_stock[3] -= 2;
    n_checks++;
    if (o_check_mode !== 1 || o_check_busy !== 1) begin
      n_fail++; $display("FAIL t1_check got mode=%0d busy=%0d want 1/1", o_check_mode, o_check_busy);
    end
    n_checks++;
    if (o_post_mode !== 2 || o_post_total !== 1000) begin
      n_fail++; $display("FAIL t1_total got mode=%0d total=%0d want 2/1000", o_post_mode, o_post_total);
    end
    n_checks++;
    if (o_latency !== 3) begin
      n_fail++; $display("FAIL t1_latency got %0d want 3", o_latency);
    end
    n_checks++;
    if (o_reqs !== 2 || o_req_in_disp !== 0) begin
      n_fail++; $display("FAIL t1_reqs got %0d (in dispense %0d) want 2 (0)", o_reqs, o_req_in_disp);
    end
    n_checks++;
    if (o_fin_mode !== 4 || o_fin_qty !== 0 || o_fin_total !== 1000) begin
      n_fail++; $display("FAIL t1_done got mode=%0d qty=%0d total=%0d want 4/0/1000",
                         o_fin_mode, o_fin_qty, o_fin_total);
    end
    n_checks++;
    if (o_hold !== HOLD || o_idle_all !== 1 || o_timeout !== 0) begin
      n_fail++; $display("FAIL t1_hold got hold=%0d idle=%0d to=%0d want %0d/1/0",
                         o_hold, o_idle_all, o_timeout, HOLD);
    end
    $display("order: code=3 qty=2 total=%0d reqs=%0d", o_post_total, o_reqs);
    test_stock_probe(3, model_stock[3]);
  endtask

  task automatic test_no_stock();
    run_order(5, 10, 77, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if (o_check_mode !== 1 || o_post_mode !== 5 || o_reqs !== 0 || o_fin_total !== 0) begin
      n_fail++; $display("FAIL t2_error got check=%0d post=%0d reqs=%0d total=%0d want 1/5/0/0",
                         o_check_mode, o_post_mode, o_reqs, o_fin_total);
    end
    n_checks++;
    if (o_hold !== HOLD || o_idle_all !== 1) begin
      n_fail++; $display("FAIL t2_hold got hold=%0d idle=%0d want %0d/1", o_hold, o_idle_all, HOLD);
    end
    $display("nostock: code=5 qty=10 mode=%0d", o_post_mode);
    test_stock_probe(5, model_stock[5]);
  endtask

  task automatic test_restock();
    code_sel = 4'd3; restock = 1'b1;
    step();
    restock = 1'b0;
    model_stock[3] = INIT;
    $display("restock: code=3");
    test_stock_probe(3, model_stock[3]);
    // Restock held high through a whole order must be ignored outside IDLE.
    run_order(6, 3, 10, 1, 0, 1'b0, 1'b1);
    model_stock[6] -= 3;
    n_checks++;
    if (o_fin_mode !== 4 || o_reqs !== 3) begin
      n_fail++; $display("FAIL t7_busy_order got mode=%0d reqs=%0d want 4/3", o_fin_mode, o_reqs);
    end
    test_stock_probe(6, model_stock[6]);
  endtask

  task automatic test_cancel_wait();
    run_order(7, 3, 100, 2, 1, 1'b0, 1'b0);
    model_stock[7] -= 1;
    n_checks++;
    if (o_reqs !== 1 || o_fin_mode !== 4 || o_fin_qty !== 2 || o_fin_total !== 300) begin
      n_fail++; $display("FAIL t3_cancel got reqs=%0d mode=%0d qty=%0d total=%0d want 1/4/2/300",
                         o_reqs, o_fin_mode, o_fin_qty, o_fin_total);
    end
    $display("cancel: code=7 reqs=%0d qty_now=%0d", o_reqs, o_fin_qty);
    test_stock_probe(7, model_stock[7]);
  endtask

  task automatic test_timeout();
    run_order(8, 1, 20, 0, 0, 1'b1, 1'b0);
    n_checks++;
    if (o_req_cycles !== TO || o_reqs !== 1) begin
      n_fail++; $display("FAIL t4_req_len got %0d cycles (%0d pulses) want %0d (1)", o_req_cycles, o_reqs, TO);
    end
    n_checks++;
    if (o_fin_mode !== 5 || o_fin_req !== 0 || o_hold !== HOLD) begin
      n_fail++; $display("FAIL t4_error got mode=%0d req=%0d hold=%0d want 5/0/%0d",
                         o_fin_mode, o_fin_req, o_hold, HOLD);
    end
    $display("timeout: code=8 req_cycles=%0d", o_req_cycles);
    test_stock_probe(8, model_stock[8]);
  endtask

  task automatic test_ignored_orders();
    code_sel = 4'd1; qty_sel = 5'd2; btn_order = 1'b1; btn_cancel = 1'b1;
    step();
    btn_order = 1'b0; btn_cancel = 1'b0;
    n_checks++;
    if (mode !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t5_order_cancel got mode=%0d busy=%0b want 0/0", mode, busy);
    end
    qty_sel = 5'd0; btn_order = 1'b1;
    step();
    btn_order = 1'b0;
    n_checks++;
    if (mode !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t6_zero_qty got mode=%0d busy=%0b want 0/0", mode, busy);
    end
    code_sel = 4'd1; disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    $display("ignored: same-cycle cancel, zero qty, stray ack mode=%0d", mode);
    test_stock_probe(1, model_stock[1]);
  endtask

  task automatic test_random();
    int code, qty, prc, dly, cmode;
    for (int it = 0; it < 14; it++) begin
      code = $urandom_range(0, 15);
      qty  = $urandom_range(1, 6);
      prc  = $urandom_range(0, 1023);
      dly  = $urandom_range(0, 3);
      cmode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, qty) : 0;
      if ($urandom_range(0, 4) == 0) begin
        code_sel = 4'(code); restock = 1'b1;
        step();
        restock = 1'b0;
        model_stock[code] = INIT;
      end
      predict(code, qty, prc, cmode, 1'b0);
      run_order(code, qty, prc, dly, cmode, 1'b0, 1'b0);
      model_stock[code] -= e_used;
      n_checks++;
      if (o_post_mode !== e_post || o_reqs !== e_reqs || o_fin_mode !== e_fin_mode ||
          o_fin_qty !== e_fin_qty || o_timeout !== 0) begin
        n_fail++;
        $display("FAIL rnd_flow it=%0d got post=%0d reqs=%0d fin=%0d qty=%0d to=%0d want %0d/%0d/%0d/%0d/0",
                 it, o_post_mode, o_reqs, o_fin_mode, o_fin_qty, o_timeout,
                 e_post, e_reqs, e_fin_mode, e_fin_qty);
      end
      n_checks++;
      if (o_fin_total !== e_total || o_hold !== HOLD || o_idle_all !== 1 ||
          (e_reqs > 0 && o_latency !== 3)) begin
        n_fail++;
        $display("FAIL rnd_total it=%0d got total=%0d hold=%0d idle=%0d lat=%0d want %0d/%0d/1/3",
                 it, o_fin_total, o_hold, o_idle_all, o_latency, e_total, HOLD);
      end
      $display("random: it=%0d code=%0d qty=%0d price=%0d cancel=%0d -> mode=%0d total=%0d stock=%0d",
               it, code, qty, prc, cmode, o_fin_mode, o_fin_total, model_stock[code]);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    run_order(3, 1, 5, 0, 0, 1'b0, 1'b0);
    code_sel = 4'd2; qty_sel = 5'd3; price = 10'd40; btn_order = 1'b1;
    step();
    btn_order = 1'b0;
    guard = 0;
    while (!disp_req && guard < 20) begin
      step(); guard++;
    end
    n_checks++;
    if (disp_req !== 1'b1) begin
      n_fail++; $display("FAIL t8_reach_wait got req=%0b want 1", disp_req);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_stock[i] = INIT;
    n_checks++;
    if ({mode, disp_req, qty_now, total_sum, busy} !== 29'd0) begin
      n_fail++;
      $display("FAIL t8_reset_mid got mode=%0d req=%0b qty=%0d total=%0d busy=%0b want all 0",
               mode, disp_req, qty_now, total_sum, busy);
    end
    $display("reset_mid: mode=%0d req=%0b", mode, disp_req);
    test_stock_probe(3, model_stock[3]);
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_no_stock();
    test_restock();
    test_cancel_wait();
    test_timeout();
    test_ignored_orders();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
